// File: rtl/seq_divider_pkg.sv
// Shared M-extension divide definitions.
// Holds the state encoding of the iterative divider FSM.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } type_div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Responder on the start/done handshake; sign fix-up is left to the wrapper.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [XLEN-1:0] opr1_i,
   input  logic [XLEN-1:0] opr2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] quo_o,
   output logic [XLEN-1:0] rem_o,
   output type_div_state_e dbg_state_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   // Handshake: start_i is taken only in IDLE when abort_i is low; done_o is
   // a one-cycle pulse and quo_o/rem_o are meaningful only while it is high.
   type_div_state_e state_q, state_d;
   logic [XLEN-1:0] quo_q, rem_q, dvsr_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN:0]   diff;
   logic            accept;
   logic            div_zero;

   assign div_zero = (opr2_i == '0);
   assign diff     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               accept  = 1'b1;
               state_d = div_zero ? DONE : CALC;
            end
         end
         CALC:    if (cnt_q == CNT_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_i) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvsr_q <= '0;
         cnt_q  <= '0;
      end else if (accept) begin
         dvsr_q <= opr2_i;
         cnt_q  <= '0;
         // Division by zero follows RISC-V: all-ones quotient, dividend as remainder.
         if (div_zero) begin
            quo_q <= '1;
            rem_q <= opr1_i;
         end else begin
            quo_q <= opr1_i;
            rem_q <= '0;
         end
      end else if (state_q == CALC) begin
         if (!diff[XLEN]) begin
            rem_q <= diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_q <= {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
         end
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign done_o      = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign quo_o       = quo_q;
   assign rem_o       = rem_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a quotient/remainder scoreboard.
module tb_seq_divider;
   import seq_divider_pkg::*;

   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 1;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            abort;
   logic [XLEN-1:0] opr1, opr2;
   logic            busy, done;
   logic [XLEN-1:0] quo, rem;
   type_div_state_e dbg_state;

   logic [2*XLEN-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   seq_divider #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
      .opr1_i(opr1), .opr2_i(opr2), .busy_o(busy), .done_o(done),
      .quo_o(quo), .rem_o(rem), .dbg_state_o(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; pulses start for one cycle and checks the result.
   task automatic do_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] eq, input logic [XLEN-1:0] er);
      int lat;
      bit seen;
      logic [2*XLEN-1:0] e;
      exp_q.push_back({eq, er});
      start = 1'b1;
      opr1  = a;
      opr2  = b;
      lat   = 0;
      seen  = 1'b0;
      while (!seen && lat < LAT + 8) begin
         @(negedge clk);
         lat++;
         if (lat == 1) start = 1'b0;
         if (done) seen = 1'b1;
      end
      check("done_seen", 64'(seen), 64'd1);
      e = exp_q.pop_front();
      if (seen) begin
         check("latency", 64'(lat), (b == '0) ? 64'd1 : 64'(LAT));
         check("quo", 64'(quo), 64'(e[2*XLEN-1:XLEN]));
         check("rem", 64'(rem), 64'(e[XLEN-1:0]));
         @(negedge clk);
         check("busy_after", 64'(busy), 64'd0);
         check("done_after", 64'(done), 64'd0);
      end
   endtask

   initial begin : stim
      int dones, cyc;
      logic [2*XLEN-1:0] e;
      logic [XLEN-1:0] a, b;

      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      opr1  = '0;
      opr2  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_quo", 64'(quo), 64'd0);
      check("rst_rem", 64'(rem), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(IDLE));

      do_div(32'd100, 32'd7, 32'd14, 32'd2);
      do_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      do_div(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);
      do_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
      do_div(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
      do_div(32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3);

      // start held high: one completion, then a second request in the following IDLE cycle
      dones = 0;
      cyc   = 0;
      start = 1'b1;
      opr1  = 32'd20;
      opr2  = 32'd6;
      exp_q.push_back({32'd3, 32'd2});
      while (dones < 2 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            dones++;
            e = exp_q.pop_front();
            check("held_lat", 64'(cyc), (dones == 1) ? 64'(LAT) : 64'(2 * LAT + 1));
            check("held_quo", 64'(quo), 64'(e[2*XLEN-1:XLEN]));
            check("held_rem", 64'(rem), 64'(e[XLEN-1:0]));
            if (dones == 1) begin
               opr1 = 32'd50;
               opr2 = 32'd7;
               exp_q.push_back({32'd7, 32'd1});
            end else begin
               start = 1'b0;
            end
         end else if (busy) begin
            opr1 = $urandom;
            opr2 = $urandom;
         end
      end
      start = 1'b0;
      check("held_dones", 64'(dones), 64'd2);
      exp_q.delete();
      repeat (2) @(negedge clk);

      // abort in the tenth CALC cycle
      start = 1'b1;
      opr1  = 32'd100;
      opr2  = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_state", 64'(dbg_state), 64'(IDLE));
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      do_div(32'd9, 32'd4, 32'd2, 32'd1);

      // abort together with start in IDLE drops the request
      start = 1'b1;
      abort = 1'b1;
      opr1  = 32'd9;
      opr2  = 32'd0;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_busy", 64'(busy), 64'd0);
      check("abort_start_done", 64'(done), 64'd0);

      // abort during DONE: the pulse is still visible
      start = 1'b1;
      opr1  = 32'd7;
      opr2  = 32'd0;
      @(negedge clk);
      start = 1'b0;
      check("abort_done_pulse", 64'(done), 64'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_done_idle", 64'(busy), 64'd0);

      // asynchronous reset mid-CALC
      start = 1'b1;
      opr1  = 32'd77;
      opr2  = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_quo", 64'(quo), 64'd0);
      check("arst_rem", 64'(rem), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("arst_no_done", 64'(dones), 64'd0);
      do_div(32'd1000, 32'd10, 32'd100, 32'd0);

      for (int i = 0; i < 1500; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = $urandom_range(1, 255);
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom_range(0, 3);
         endcase
         if (b == '0) do_div(a, b, '1, a);
         else         do_div(a, b, a / b, a % b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
